exception_ctrl: RTL and testbench

//  Exception initiator paired with cp0_reg: samples MEM-stage exception flags and pending interrupts, picks one

---
 rtl/exception_ctrl.sv | 163 ++++++++++++++++
 tb/tb_exception_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: fixed-priority exception initiator for cp0_reg; drives pipeline flush and handler PC.
// Define EXC_IRQ_SYNC_EN to pass interrupt_input through a two-flop synchronizer (3-cycle IRQ latency).
module exception_ctrl #(
  parameter logic [31:0] HANDLER_ADDR      = 32'h0000_0020,
  parameter int unsigned FLUSH_HOLD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_input,
  input  logic        syscall_input,
  input  logic        invalid_instruction_input,
  input  logic        trap_input,
  input  logic        overflow_input,
  input  logic        eret_input,
  input  logic [31:0] current_instruction_address_input,
  input  logic        is_in_delay_slot_input,
  input  logic [5:0]  interrupt_input,
  input  logic [31:0] cp0_status_input,
  input  logic [31:0] cp0_cause_input,
  input  logic [31:0] cp0_epc_input,
  output logic [31:0] exception_type_output,
  output logic [31:0] current_instruction_address_output,
  output logic        is_in_delay_slot_output,
  output logic        flush_output,
  output logic [31:0] new_pc_output,
  output logic        busy_output
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_FLUSH = 2'd1;
  localparam logic [1:0]  ST_HOLD  = 2'd2;
  localparam logic [3:0]  HOLD_LOAD = 4'(FLUSH_HOLD_CYCLES);

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_INV  = 32'ha;
  localparam logic [31:0] EXC_TRAP = 32'hd;
  localparam logic [31:0] EXC_OVF  = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic        delay_q, delay_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic [5:0]  irq_s;
  logic [7:0]  pending_ip;
  logic        irq_take;
  logic [31:0] code;

`ifdef EXC_IRQ_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= interrupt_input;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = interrupt_input;
`endif

  assign pending_ip = {irq_s, cp0_cause_input[9:8]} & cp0_status_input[15:8];
  assign irq_take   = (pending_ip != 8'd0) & cp0_status_input[0] & ~cp0_status_input[1];

  // Bubbles select nothing, so an interrupt always lands on a real instruction.
  always_comb begin
    code = '0;
    if (valid_input) begin
      if (irq_take)                       code = EXC_INT;
      else if (syscall_input)             code = EXC_SYS;
      else if (invalid_instruction_input) code = EXC_INV;
      else if (trap_input)                code = EXC_TRAP;
      else if (overflow_input)            code = EXC_OVF;
      else if (eret_input)                code = EXC_ERET;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    addr_d   = addr_q;
    delay_d  = delay_q;
    flush_d  = flush_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (code != 32'd0) begin
          state_d  = ST_FLUSH;
          type_d   = code;
          addr_d   = current_instruction_address_input;
          delay_d  = is_in_delay_slot_input;
          flush_d  = 1'b1;
          new_pc_d = (code == EXC_ERET) ? cp0_epc_input : HANDLER_ADDR;
        end
      end
      ST_FLUSH: begin
        state_d  = ST_HOLD;
        cnt_d    = HOLD_LOAD;
        type_d   = '0;
        flush_d  = 1'b0;
        new_pc_d = '0;
      end
      ST_HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        type_d   = '0;
        flush_d  = 1'b0;
        new_pc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      delay_q  <= 1'b0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      delay_q  <= delay_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign exception_type_output              = type_q;
  assign current_instruction_address_output = addr_q;
  assign is_in_delay_slot_output            = delay_q;
  assign flush_output                       = flush_q;
  assign new_pc_output                      = new_pc_q;
  assign busy_output                        = (state_q == ST_FLUSH) | (state_q == ST_HOLD);

  // Only IE, EXL, IM and the software IP bits matter here.
  logic unused_bits;
  assign unused_bits = ^{cp0_status_input[31:16], cp0_status_input[7:2],
                         cp0_cause_input[31:10], cp0_cause_input[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed self-checking bench for exception_ctrl, valid with or without EXC_IRQ_SYNC_EN.
module tb_exception_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_input;
  logic        syscall_input, invalid_instruction_input, trap_input, overflow_input, eret_input;
  logic [31:0] current_instruction_address_input;
  logic        is_in_delay_slot_input;
  logic [5:0]  interrupt_input;
  logic [31:0] cp0_status_input, cp0_cause_input, cp0_epc_input;
  logic [31:0] exception_type_output, current_instruction_address_output, new_pc_output;
  logic        is_in_delay_slot_output, flush_output, busy_output;

  int assertCount = 0;
  int failCount   = 0;

`ifdef EXC_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  localparam logic [4:0] F_SYS  = 5'b10000;
  localparam logic [4:0] F_INV  = 5'b01000;
  localparam logic [4:0] F_TRAP = 5'b00100;
  localparam logic [4:0] F_OVF  = 5'b00010;
  localparam logic [4:0] F_ERET = 5'b00001;

  exception_ctrl dut (
    .clock                              (clock),
    .reset                              (reset),
    .valid_input                        (valid_input),
    .syscall_input                      (syscall_input),
    .invalid_instruction_input          (invalid_instruction_input),
    .trap_input                         (trap_input),
    .overflow_input                     (overflow_input),
    .eret_input                         (eret_input),
    .current_instruction_address_input  (current_instruction_address_input),
    .is_in_delay_slot_input             (is_in_delay_slot_input),
    .interrupt_input                    (interrupt_input),
    .cp0_status_input                   (cp0_status_input),
    .cp0_cause_input                    (cp0_cause_input),
    .cp0_epc_input                      (cp0_epc_input),
    .exception_type_output              (exception_type_output),
    .current_instruction_address_output (current_instruction_address_output),
    .is_in_delay_slot_output            (is_in_delay_slot_output),
    .flush_output                       (flush_output),
    .new_pc_output                      (new_pc_output),
    .busy_output                        (busy_output)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] flags, input logic [31:0] pc,
                               input logic ds, input logic [5:0] irq, input logic [31:0] status,
                               input logic [31:0] cause, input logic [31:0] epc);
    valid_input                       = v;
    {syscall_input, invalid_instruction_input, trap_input, overflow_input, eret_input} = flags;
    current_instruction_address_input = pc;
    is_in_delay_slot_input            = ds;
    interrupt_input                   = irq;
    cp0_status_input                  = status;
    cp0_cause_input                   = cause;
    cp0_epc_input                     = epc;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 5'b0, 32'h0, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Called right after the FLUSH cycle has been checked and inputs cleared: two HOLD cycles then IDLE.
  task automatic holdPhase(input string tag);
    tick();
    checkOutput({tag, "_hold1_flush"}, 32'(flush_output), 32'd0);
    checkOutput({tag, "_hold1_type"}, exception_type_output, 32'h0);
    checkOutput({tag, "_hold1_newpc"}, new_pc_output, 32'h0);
    checkOutput({tag, "_hold1_busy"}, 32'(busy_output), 32'd1);
    tick();
    checkOutput({tag, "_hold2_busy"}, 32'(busy_output), 32'd1);
    tick();
    checkOutput({tag, "_idle_busy"}, 32'(busy_output), 32'd0);
    checkOutput({tag, "_idle_flush"}, 32'(flush_output), 32'd0);
  endtask

  logic [4:0]  flagTab [4];
  logic [31:0] codeTab [4];

  initial begin
    flagTab[0] = F_INV | F_TRAP;                           codeTab[0] = 32'ha;
    flagTab[1] = F_TRAP | F_OVF;                           codeTab[1] = 32'hd;
    flagTab[2] = F_OVF;                                    codeTab[2] = 32'hc;
    flagTab[3] = F_SYS | F_INV | F_TRAP | F_OVF | F_ERET;  codeTab[3] = 32'h8;

    reset = 1'b0;
    clearInputs();
    tick();
    tick();
    checkOutput("rst_type", exception_type_output, 32'h0);
    checkOutput("rst_addr", current_instruction_address_output, 32'h0);
    checkOutput("rst_delay", 32'(is_in_delay_slot_output), 32'd0);
    checkOutput("rst_flush", 32'(flush_output), 32'd0);
    checkOutput("rst_newpc", new_pc_output, 32'h0);
    checkOutput("rst_busy", 32'(busy_output), 32'd0);
    reset = 1'b1;
    tick();

    // Syscall: one-cycle latency, handler address, then hold.
    applyStimulus(1'b1, F_SYS, 32'h100, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("s1_type", exception_type_output, 32'h8);
    checkOutput("s1_addr", current_instruction_address_output, 32'h100);
    checkOutput("s1_delay", 32'(is_in_delay_slot_output), 32'd0);
    checkOutput("s1_flush", 32'(flush_output), 32'd1);
    checkOutput("s1_newpc", new_pc_output, 32'h20);
    checkOutput("s1_busy", 32'(busy_output), 32'd1);
    clearInputs();
    holdPhase("s1");
    checkOutput("s1_addr_held", current_instruction_address_output, 32'h100);

    // Hardware interrupt on line 0 (IP2 enabled by IM bit 10).
    applyStimulus(1'b1, 5'b0, 32'h200, 1'b1, 6'h01, 32'h0000_0401, 32'h0, 32'h0);
    for (int i = 1; i < IRQ_LAT; i++) begin
      tick();
      checkOutput("s2_early_flush", 32'(flush_output), 32'd0);
    end
    tick();
    checkOutput("s2_type", exception_type_output, 32'h1);
    checkOutput("s2_addr", current_instruction_address_output, 32'h200);
    checkOutput("s2_delay", 32'(is_in_delay_slot_output), 32'd1);
    checkOutput("s2_flush", 32'(flush_output), 32'd1);
    checkOutput("s2_newpc", new_pc_output, 32'h20);
    clearInputs();
    holdPhase("s2");
    checkOutput("s2_delay_held", 32'(is_in_delay_slot_output), 32'd1);

    // Software interrupt via Cause IP0: never synchronized, always one cycle.
    applyStimulus(1'b1, 5'b0, 32'h600, 1'b0, 6'h0, 32'h0000_0101, 32'h0000_0100, 32'h0);
    tick();
    checkOutput("sw_type", exception_type_output, 32'h1);
    checkOutput("sw_flush", 32'(flush_output), 32'd1);
    clearInputs();
    holdPhase("sw");

    // Simultaneous syscall+overflow+eret: single flush, nothing queued.
    applyStimulus(1'b1, F_SYS | F_OVF | F_ERET, 32'h300, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0000_1234);
    tick();
    checkOutput("s3_type", exception_type_output, 32'h8);
    checkOutput("s3_newpc", new_pc_output, 32'h20);
    clearInputs();
    holdPhase("s3");
    tick();
    checkOutput("s3_noreplay1", 32'(flush_output), 32'd0);
    tick();
    checkOutput("s3_noreplay2", 32'(flush_output), 32'd0);

    // Priority table.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, flagTab[i], 32'h400 + 32'(i * 4), 1'b0, 6'h0, 32'h0, 32'h0, 32'h0000_1234);
      tick();
      checkOutput($sformatf("prio%0d_type", i), exception_type_output, codeTab[i]);
      checkOutput($sformatf("prio%0d_addr", i), current_instruction_address_output, 32'h400 + 32'(i * 4));
      clearInputs();
      holdPhase($sformatf("prio%0d", i));
    end

    // eret with EXL=0: reported, returns to EPC.
    applyStimulus(1'b1, F_ERET, 32'h700, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0000_1234);
    tick();
    checkOutput("s4a_type", exception_type_output, 32'he);
    checkOutput("s4a_newpc", new_pc_output, 32'h1234);
    clearInputs();
    holdPhase("s4a");

    // Pending IRQ on bubbles is never taken; then eret with EXL=1 masks it.
    applyStimulus(1'b0, 5'b0, 32'h800, 1'b0, 6'h01, 32'h0000_0401, 32'h0, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bubble_flush", 32'(flush_output), 32'd0);
    end
    applyStimulus(1'b1, F_ERET, 32'h800, 1'b0, 6'h01, 32'h0000_0403, 32'h0, 32'h0000_1234);
    tick();
    checkOutput("s4b_type", exception_type_output, 32'he);
    checkOutput("s4b_newpc", new_pc_output, 32'h1234);
    clearInputs();
    holdPhase("s4b");

    // Async reset mid-FLUSH.
    applyStimulus(1'b1, F_SYS, 32'h900, 1'b1, 6'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("s5_flush_pre", 32'(flush_output), 32'd1);
    applyStimulus(1'b0, F_SYS, 32'h900, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("s5_rst_flush", 32'(flush_output), 32'd0);
    checkOutput("s5_rst_type", exception_type_output, 32'h0);
    checkOutput("s5_rst_busy", 32'(busy_output), 32'd0);
    checkOutput("s5_rst_addr", current_instruction_address_output, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("s5_post_flush", 32'(flush_output), 32'd0);
    checkOutput("s5_post_busy", 32'(busy_output), 32'd0);

    // Trap, then syscall during HOLD is ignored until the first IDLE cycle.
    applyStimulus(1'b1, F_TRAP, 32'ha00, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("s5_trap_type", exception_type_output, 32'hd);
    clearInputs();
    tick();
    applyStimulus(1'b1, F_SYS, 32'hb00, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("s5_hold_flush", 32'(flush_output), 32'd0);
    tick();
    checkOutput("s5_idle_flush", 32'(flush_output), 32'd0);
    checkOutput("s5_idle_busy", 32'(busy_output), 32'd0);
    tick();
    checkOutput("s5_late_type", exception_type_output, 32'h8);
    checkOutput("s5_late_addr", current_instruction_address_output, 32'hb00);
    checkOutput("s5_late_flush", 32'(flush_output), 32'd1);
    clearInputs();
    holdPhase("s5_late");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
